// File: rtl/rsp_s1_prep_ahbic_out_mp.sv
// AHB-Lite bus-matrix output stage with integrated per-slave arbiter.
// Define RSP_AHBIC_OUT_RR_EN for round-robin; fixed priority otherwise.
module rsp_s1_prep_ahbic_out_mp #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [NUM_PORTS-1:0]           sel_op,
  input  logic [NUM_PORTS-1:0]           held_tran_op,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_op,
  input  logic [NUM_PORTS*2-1:0]         trans_op,
  input  logic [NUM_PORTS-1:0]           write_op,
  input  logic [NUM_PORTS*3-1:0]         size_op,
  input  logic [NUM_PORTS*3-1:0]         burst_op,
  input  logic [NUM_PORTS*4-1:0]         prot_op,
  input  logic [NUM_PORTS*4-1:0]         master_op,
  input  logic [NUM_PORTS-1:0]           mastlock_op,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_op,
  input  logic                           HREADYOUTM,
  output logic [NUM_PORTS-1:0]           active_op,
  output logic                           HSELM,
  output logic [ADDR_WIDTH-1:0]          HADDRM,
  output logic [1:0]                     HTRANSM,
  output logic                           HWRITEM,
  output logic [2:0]                     HSIZEM,
  output logic [2:0]                     HBURSTM,
  output logic [3:0]                     HPROTM,
  output logic [3:0]                     HMASTERM,
  output logic                           HMASTLOCKM,
  output logic [DATA_WIDTH-1:0]          HWDATAM,
  output logic                           HREADYMUXM
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] r_addr_port;
  logic          r_no_port;
  logic [PW-1:0] r_data_port;
  logic          r_slave_sel;
  logic          r_hsel_lock;
  logic [3:0]    r_beat_cnt;
  logic [PW-1:0] r_last_grant;

  logic                  w_sel;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [1:0]            w_trans;
  logic                  w_write;
  logic [2:0]            w_size;
  logic [2:0]            w_burst;
  logic [3:0]            w_prot;
  logic [3:0]            w_master;
  logic                  w_lock;
  logic [NUM_PORTS-1:0]  w_req;
  logic                  w_any;
  logic [PW-1:0]         w_base;
  logic [PW-1:0]         w_win;
  logic                  w_hit;
  logic                  w_lock_nxt;
  logic                  w_hlock_arb;
  logic [3:0]            w_beat_nxt;
  logic                  w_nseq;
  logic                  w_seq;
  logic                  w_idle;

  always_comb begin
    w_sel    = 1'b0;
    w_addr   = '0;
    w_trans  = '0;
    w_write  = 1'b0;
    w_size   = '0;
    w_burst  = '0;
    w_prot   = '0;
    w_master = '0;
    w_lock   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_addr_port == PW'(i)) begin
        w_sel    = sel_op[i];
        w_addr   = addr_op[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_trans  = trans_op[i*2 +: 2];
        w_write  = write_op[i];
        w_size   = size_op[i*3 +: 3];
        w_burst  = burst_op[i*3 +: 3];
        w_prot   = prot_op[i*4 +: 4];
        w_master = master_op[i*4 +: 4];
        w_lock   = mastlock_op[i];
      end
    end
  end

  assign HSELM      = ~r_no_port & w_sel;
  assign HADDRM     = r_no_port ? '0 : w_addr;
  assign HTRANSM    = r_no_port ? '0 : w_trans;
  assign HWRITEM    = ~r_no_port & w_write;
  assign HSIZEM     = r_no_port ? '0 : w_size;
  assign HBURSTM    = r_no_port ? '0 : w_burst;
  assign HPROTM     = r_no_port ? '0 : w_prot;
  assign HMASTERM   = r_no_port ? '0 : w_master;
  assign HMASTLOCKM = ~r_no_port & w_lock;
  assign HREADYMUXM = r_slave_sel ? HREADYOUTM : 1'b1;

  always_comb begin
    active_op = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      active_op[i] = ~r_no_port & (r_addr_port == PW'(i));
  end

  // Write data follows the owner of the previous accepted address phase
  always_comb begin
    HWDATAM = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (r_data_port == PW'(i))
        HWDATAM = wdata_op[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_lock_nxt  = (HSELM & HTRANSM[1] & HMASTLOCKM) ? 1'b1 :
                       (~HMASTLOCKM ? 1'b0 : r_hsel_lock);
  assign w_hlock_arb = HMASTLOCKM & (r_hsel_lock | HSELM);

  assign w_nseq = (HTRANSM == 2'b10) & HSELM;
  assign w_seq  = (HTRANSM == 2'b11);
  assign w_idle = (HTRANSM == 2'b00);

  always_comb begin
    w_beat_nxt = r_beat_cnt;
    unique case (1'b1)
      w_nseq: begin
        case (HBURSTM)
          3'd2, 3'd3: w_beat_nxt = 4'd3;
          3'd4, 3'd5: w_beat_nxt = 4'd7;
          3'd6, 3'd7: w_beat_nxt = 4'd15;
          default:    w_beat_nxt = 4'd0;
        endcase
      end
      w_seq:  w_beat_nxt = (r_beat_cnt == 4'd0) ? 4'd0 : r_beat_cnt - 4'd1;
      w_idle: w_beat_nxt = 4'd0;
      default: w_beat_nxt = r_beat_cnt;
    endcase
  end

  assign w_req = held_tran_op & sel_op;
  assign w_any = |w_req;

`ifdef RSP_AHBIC_OUT_RR_EN
  assign w_base = r_last_grant;
`else
  // Fixed priority: search always starts after the top index, so port 0 first
  assign w_base = PW'(NUM_PORTS - 1) | (r_last_grant & PW'(0));
`endif

  always_comb begin
    w_win = r_addr_port;
    w_hit = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!w_hit && w_req[(int'(w_base) + k) % NUM_PORTS]) begin
        w_win = PW'((int'(w_base) + k) % NUM_PORTS);
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr_port  <= '0;
      r_no_port    <= 1'b1;
      r_data_port  <= '0;
      r_slave_sel  <= 1'b0;
      r_hsel_lock  <= 1'b0;
      r_beat_cnt   <= '0;
      r_last_grant <= PW'(NUM_PORTS - 1);
    end else if (HREADYMUXM) begin
      r_data_port <= r_addr_port;
      r_slave_sel <= HSELM;
      r_hsel_lock <= w_lock_nxt;
      r_beat_cnt  <= w_beat_nxt;
      if (!r_no_port && (w_hlock_arb || (w_beat_nxt != 4'd0))) begin
        r_addr_port <= r_addr_port;
      end else if (w_any) begin
        r_addr_port  <= w_win;
        r_no_port    <= 1'b0;
        r_last_grant <= w_win;
      end else begin
        r_no_port <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsp_s1_prep_ahbic_out_mp.sv
// Scoreboard bench for rsp_s1_prep_ahbic_out_mp.
// Grant-order expectations follow RSP_AHBIC_OUT_RR_EN when defined.
module tb_rsp_s1_prep_ahbic_out_mp;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [NP-1:0]     sel_op, held_tran_op, write_op, mastlock_op;
  logic [NP*AW-1:0]  addr_op;
  logic [NP*2-1:0]   trans_op;
  logic [NP*3-1:0]   size_op, burst_op;
  logic [NP*4-1:0]   prot_op, master_op;
  logic [NP*DW-1:0]  wdata_op;
  logic              HREADYOUTM;
  logic [NP-1:0]     active_op;
  logic              HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
  logic [AW-1:0]     HADDRM;
  logic [1:0]        HTRANSM;
  logic [2:0]        HSIZEM, HBURSTM;
  logic [3:0]        HPROTM, HMASTERM;
  logic [DW-1:0]     HWDATAM;

  rsp_s1_prep_ahbic_out_mp #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .sel_op(sel_op), .held_tran_op(held_tran_op),
    .addr_op(addr_op), .trans_op(trans_op),
    .write_op(write_op), .size_op(size_op),
    .burst_op(burst_op), .prot_op(prot_op),
    .master_op(master_op), .mastlock_op(mastlock_op),
    .wdata_op(wdata_op), .HREADYOUTM(HREADYOUTM),
    .active_op(active_op), .HSELM(HSELM),
    .HADDRM(HADDRM), .HTRANSM(HTRANSM),
    .HWRITEM(HWRITEM), .HSIZEM(HSIZEM),
    .HBURSTM(HBURSTM), .HPROTM(HPROTM),
    .HMASTERM(HMASTERM), .HMASTLOCKM(HMASTLOCKM),
    .HWDATAM(HWDATAM), .HREADYMUXM(HREADYMUXM)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       nm;
    logic [3:0]  act;
    logic        sel;
    logic [31:0] addr;
    logic        rdy;
    logic [31:0] wd;
    logic        cwd;
  } exp_t;

  exp_t q[$];
  int n_tot  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [31:0] wd [NP];

  always @(negedge HCLK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = q.pop_front();
      ok = (active_op === e.act) && (HSELM === e.sel) &&
           (HADDRM === e.addr) && (HREADYMUXM === e.rdy) &&
           (!e.cwd || (HWDATAM === e.wd));
      n_tot++;
      if (ok) n_pass++;
      else begin
        n_fail++;
        $display("FAIL %s: got act=%b sel=%b addr=%h rdy=%b wd=%h want act=%b sel=%b addr=%h rdy=%b wd=%h(chk=%b)",
                 e.nm, active_op, HSELM, HADDRM, HREADYMUXM, HWDATAM,
                 e.act, e.sel, e.addr, e.rdy, e.wd, e.cwd);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic sel, input logic [31:0] addr,
                     input logic rdy, input logic [31:0] w,
                     input logic cwd);
    exp_t e;
    e.nm = nm; e.act = act; e.sel = sel; e.addr = addr;
    e.rdy = rdy; e.wd = w; e.cwd = cwd;
    q.push_back(e);
    @(posedge HCLK); #1;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK); #1;
    end
  endtask

  task automatic sp(input int i, input logic s, input logic h,
                    input logic [1:0] t, input logic [2:0] b,
                    input logic l, input logic [31:0] a);
    sel_op[i]             = s;
    held_tran_op[i]       = h;
    trans_op[i*2 +: 2]    = t;
    burst_op[i*3 +: 3]    = b;
    mastlock_op[i]        = l;
    addr_op[i*AW +: AW]   = a;
  endtask

  task automatic set_wd(input int i, input logic [31:0] v);
    wd[i] = v;
    wdata_op[i*DW +: DW] = v;
  endtask

  task automatic idle();
    for (int i = 0; i < NP; i++) sp(i, 0, 0, 2'b00, 3'd0, 0, 32'h0);
    write_op = '0;
    adv(2);
  endtask

  function automatic int grant_k(input int k);
`ifdef RSP_AHBIC_OUT_RR_EN
    return (k - 1) % NP;
`else
    return 0 * k;
`endif
  endfunction

  initial begin
    int g, prev;
    HRESETn    = 1'b0;
    HREADYOUTM = 1'b1;
    sel_op = '0; held_tran_op = '0; write_op = '0; mastlock_op = '0;
    addr_op = '0; trans_op = '0; size_op = '0; burst_op = '0;
    prot_op = '0; master_op = '0; wdata_op = '0;
    for (int i = 0; i < NP; i++) begin
      set_wd(i, 32'hD000_0000 + i);
      master_op[i*4 +: 4] = 4'(i);
    end
    @(posedge HCLK); #1;

    chk("reset_idle", 4'b0000, 0, 32'h0, 1, wd[0], 1);
    chk("reset_wdata", 4'b0000, 0, 32'h0, 1, wd[0], 1);
    HRESETn = 1'b1;

    // All four ports request SINGLE NONSEQ continuously
    for (int i = 0; i < NP; i++)
      sp(i, 1, 1, 2'b10, 3'd0, 0, 32'h1000_0000 + 32'(i) * 32'h100);
    chk("arb_c0", 4'b0000, 0, 32'h0, 1, wd[0], 1);
    prev = 0;
    for (int k = 1; k <= 5; k++) begin
      g = grant_k(k);
      chk($sformatf("arb_c%0d", k), 4'(1 << g), 1,
          32'h1000_0000 + 32'(g) * 32'h100, 1, wd[prev], 1);
      prev = g;
    end
    idle();
    chk("no_req_idle", 4'b0000, 0, 32'h0, 1, 32'h0, 0);

    // Port 1 INCR4 at 0x1000, port 2 waits
    sp(1, 1, 1, 2'b10, 3'd3, 0, 32'h1000);
    chk("incr4_req", 4'b0000, 0, 32'h0, 1, 32'h0, 0);
    sp(2, 1, 1, 2'b10, 3'd0, 0, 32'h2000);
    chk("incr4_b0", 4'b0010, 1, 32'h1000, 1, 32'h0, 0);
    sp(1, 1, 1, 2'b11, 3'd3, 0, 32'h1004);
    chk("incr4_b1", 4'b0010, 1, 32'h1004, 1, 32'h0, 0);
    sp(1, 1, 1, 2'b11, 3'd3, 0, 32'h1008);
    chk("incr4_b2", 4'b0010, 1, 32'h1008, 1, 32'h0, 0);
    sp(1, 1, 0, 2'b11, 3'd3, 0, 32'h100C);
    chk("incr4_b3", 4'b0010, 1, 32'h100C, 1, 32'h0, 0);
    sp(1, 0, 0, 2'b00, 3'd0, 0, 32'h0);
    chk("incr4_handoff", 4'b0100, 1, 32'h2000, 1, 32'h0, 0);
    idle();

    // Port 0 locked sequence; HSEL drops while port 3 requests
    sp(0, 1, 1, 2'b10, 3'd0, 1, 32'h3000);
    chk("lock_req", 4'b0000, 0, 32'h0, 1, 32'h0, 0);
    sp(3, 1, 1, 2'b10, 3'd0, 0, 32'h4000);
    chk("lock_own", 4'b0001, 1, 32'h3000, 1, 32'h0, 0);
    sp(0, 0, 0, 2'b10, 3'd0, 1, 32'h3004);
    chk("lock_hsel_low1", 4'b0001, 0, 32'h3004, 1, 32'h0, 0);
    chk("lock_hsel_low2", 4'b0001, 0, 32'h3004, 1, 32'h0, 0);
    sp(0, 0, 0, 2'b00, 3'd0, 0, 32'h3004);
    chk("lock_release", 4'b0001, 0, 32'h3004, 1, 32'h0, 0);
    sp(0, 0, 0, 2'b00, 3'd0, 0, 32'h0);
    chk("lock_handoff", 4'b1000, 1, 32'h4000, 1, 32'h0, 0);
    idle();

    // Port 2 write stretched by three slave wait states
    sp(2, 1, 1, 2'b10, 3'd0, 0, 32'h5000);
    write_op[2] = 1'b1;
    chk("wait_req", 4'b0000, 0, 32'h0, 1, 32'h0, 0);
    sp(2, 1, 0, 2'b10, 3'd0, 0, 32'h5000);
    chk("wait_addr", 4'b0100, 1, 32'h5000, 1, 32'h0, 0);
    sp(2, 0, 0, 2'b00, 3'd0, 0, 32'h5000);
    write_op[2] = 1'b0;
    set_wd(2, 32'hA5A5_A5A5);
    sp(1, 1, 1, 2'b10, 3'd0, 0, 32'h7000);
    HREADYOUTM = 1'b0;
    for (int k = 0; k < 3; k++)
      chk($sformatf("wait_stall%0d", k), 4'b0000, 0, 32'h0, 0,
          32'hA5A5_A5A5, 1);
    HREADYOUTM = 1'b1;
    chk("wait_done", 4'b0000, 0, 32'h0, 1, 32'hA5A5_A5A5, 1);
    chk("wait_next_grant", 4'b0010, 1, 32'h7000, 1, 32'hA5A5_A5A5, 1);
    idle();

    // Reset in the middle of an INCR8
    sp(0, 1, 1, 2'b10, 3'd5, 0, 32'h6000);
    chk("incr8_req", 4'b0000, 0, 32'h0, 1, 32'h0, 0);
    chk("incr8_b0", 4'b0001, 1, 32'h6000, 1, 32'h0, 0);
    sp(0, 1, 1, 2'b11, 3'd5, 0, 32'h6004);
    chk("incr8_b1", 4'b0001, 1, 32'h6004, 1, 32'h0, 0);
    sp(0, 1, 1, 2'b11, 3'd5, 0, 32'h6008);
    chk("incr8_b2", 4'b0001, 1, 32'h6008, 1, 32'h0, 0);
    HRESETn = 1'b0;
    chk("midburst_reset", 4'b0000, 0, 32'h0, 1, wd[0], 1);
    HRESETn = 1'b1;
    sp(0, 0, 0, 2'b00, 3'd0, 0, 32'h0);
    sp(3, 1, 1, 2'b10, 3'd0, 0, 32'h4000);
    chk("post_reset_idle", 4'b0000, 0, 32'h0, 1, 32'h0, 0);
    chk("post_reset_grant", 4'b1000, 1, 32'h4000, 1, 32'h0, 0);
    idle();

    @(negedge HCLK); #1;
    if (q.size() != 0) begin
      n_tot++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
